text_command_parser: RTL and testbench

TEXT_COMMAND_PARSER -- requirements
Module: text_command_parser

---
 rtl/uart_text_pkg.sv | 36 +++
 rtl/text_byte_classifier.sv | 28 ++
 rtl/text_command_parser.sv | 166 ++++++++++++++++
 tb/tb_text_command_parser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_text_pkg.sv
// Shared definitions for the UART text command parser: command byte values,
// the FSM state encoding, the one-hot command class and a colour-digit helper.
// Ports: none (package). Optional feature macro TEXT_BACKSPACE_EN is used by importers.
package uart_text_pkg;

  localparam logic [7:0] BYTE_FONT_UP = 8'h2B;  // '+'
  localparam logic [7:0] BYTE_FONT_DN = 8'h2D;  // '-'
  localparam logic [7:0] BYTE_CLEAR   = 8'h23;  // '#'
  localparam logic [7:0] BYTE_BKSP    = 8'h08;
  localparam logic [7:0] BYTE_ESCAPE  = 8'h7E;  // '~'
  localparam logic [7:0] BYTE_COMMIT  = 8'h0D;
  localparam logic [7:0] BYTE_DIGIT_0 = 8'h30;  // '0'
  localparam logic [7:0] BYTE_DIGIT_7 = 8'h37;  // '7'

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ESCAPE = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // Exactly one field is set for any byte.
  typedef struct packed {
    logic commit;
    logic esc;
    logic bksp;
    logic clear;
    logic font_dn;
    logic font_up;
    logic chr;
  } cmd_class_t;

  function automatic logic is_colour_digit(input logic [7:0] b);
    return (b >= BYTE_DIGIT_0) && (b <= BYTE_DIGIT_7);
  endfunction

endpackage

// File: rtl/text_byte_classifier.sv
// Combinational decode of one received byte into a one-hot command class.
// Ports: data_i (byte in), cls_o (one-hot class out). No clock, no state.
// Macro TEXT_BACKSPACE_EN: when defined 0x08 is backspace, otherwise a plain character.
module text_byte_classifier
  import uart_text_pkg::*;
(
  input  logic [7:0] data_i,
  output cmd_class_t cls_o
);

  always_comb begin
    cls_o = '0;
    case (data_i)
      BYTE_FONT_UP: cls_o.font_up = 1'b1;
      BYTE_FONT_DN: cls_o.font_dn = 1'b1;
      BYTE_CLEAR:   cls_o.clear   = 1'b1;
      BYTE_ESCAPE:  cls_o.esc     = 1'b1;
      BYTE_COMMIT:  cls_o.commit  = 1'b1;
`ifdef TEXT_BACKSPACE_EN
      BYTE_BKSP:    cls_o.bksp    = 1'b1;
`else
      BYTE_BKSP:    cls_o.chr     = 1'b1;
`endif
      default:      cls_o.chr     = 1'b1;
    endcase
  end

endmodule

// File: rtl/text_command_parser.sv
// Parses a UART byte stream into a text buffer plus font size / colour, and hands a
// stable snapshot to the display side with a valid/ready handshake (update_valid one
// cycle after the triggering byte). Ports: system_clock, system_reset (async, high),
// data_received/received_flag (byte strobe in), text_buffer/text_length/font_size/
// text_colour (snapshot out), update_valid/update_ready, byte_dropped (discard pulse).
// Macro TEXT_BACKSPACE_EN enables 0x08 as backspace (see text_byte_classifier).
module text_command_parser
  import uart_text_pkg::*;
#(
  parameter int MAX_TEXT_LENGTH = 16,
  parameter int FONT_SIZE_WIDTH = 2,
  parameter int MAX_FONT_SIZE   = 3,
  parameter int MIN_FONT_SIZE   = 0,
  parameter int COLOUR_WIDTH    = 3
) (
  input  logic                         system_clock,
  input  logic                         system_reset,
  input  logic [7:0]                   data_received,
  input  logic                         received_flag,
  output logic [8*MAX_TEXT_LENGTH-1:0] text_buffer,
  output logic [5:0]                   text_length,
  output logic [FONT_SIZE_WIDTH-1:0]   font_size,
  output logic [COLOUR_WIDTH-1:0]      text_colour,
  output logic                         update_valid,
  input  logic                         update_ready,
  output logic                         byte_dropped
);

  localparam logic [5:0] LEN_MAX  = 6'(MAX_TEXT_LENGTH);
  localparam logic [5:0] LEN_LAST = 6'(MAX_TEXT_LENGTH - 1);
  localparam logic [FONT_SIZE_WIDTH-1:0] FONT_MAX = FONT_SIZE_WIDTH'(MAX_FONT_SIZE);
  localparam logic [FONT_SIZE_WIDTH-1:0] FONT_MIN = FONT_SIZE_WIDTH'(MIN_FONT_SIZE);

  state_e                       state_q, state_d;
  logic [8*MAX_TEXT_LENGTH-1:0] buf_q, buf_d;
  logic [5:0]                   len_q, len_d;
  logic [FONT_SIZE_WIDTH-1:0]   font_q, font_d;
  logic [COLOUR_WIDTH-1:0]      colour_q, colour_d;
  logic                         drop_q, drop_d;
  cmd_class_t                   cls;

  text_byte_classifier u_classifier (
    .data_i (data_received),
    .cls_o  (cls)
  );

  // State and datapath registers.
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      len_q    <= '0;
      font_q   <= FONT_MIN;
      colour_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      len_q    <= len_d;
      font_q   <= font_d;
      colour_q <= colour_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (received_flag) begin
          if (cls.chr) begin
            // The character that fills the buffer publishes it automatically.
            if (len_q == LEN_LAST) state_d = ST_UPDATE;
          end else if (cls.font_up || cls.font_dn || cls.clear || cls.commit) begin
            state_d = ST_UPDATE;
          end else if (cls.esc) begin
            state_d = ST_ESCAPE;
          end
        end
      end
      ST_ESCAPE: begin
        if (received_flag) begin
          state_d = is_colour_digit(data_received) ? ST_UPDATE : ST_IDLE;
        end
      end
      ST_UPDATE: begin
        // Clear restarts the handshake with the new contents, even if ready is high.
        if (received_flag && cls.clear) state_d = ST_UPDATE;
        else if (update_ready)          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; contents only change in UPDATE through clear.
  always_comb begin
    buf_d    = buf_q;
    len_d    = len_q;
    font_d   = font_q;
    colour_d = colour_q;
    drop_d   = 1'b0;
    if (received_flag) begin
      case (state_q)
        ST_IDLE: begin
          if (cls.chr) begin
            if (len_q == LEN_MAX) begin
              drop_d = 1'b1;
            end else begin
              for (int i = 0; i < MAX_TEXT_LENGTH; i++) begin
                if (6'(i) == len_q) buf_d[8*i +: 8] = data_received;
              end
              len_d = len_q + 6'd1;
            end
          end else if (cls.font_up) begin
            if (font_q < FONT_MAX) font_d = font_q + 1'b1;
          end else if (cls.font_dn) begin
            if (font_q > FONT_MIN) font_d = font_q - 1'b1;
          end else if (cls.clear) begin
            buf_d    = '0;
            len_d    = '0;
            font_d   = FONT_MIN;
            colour_d = '0;
          end else if (cls.bksp) begin
            // Backspace on an empty buffer is silently ignored.
            if (len_q != 6'd0) begin
              for (int i = 0; i < MAX_TEXT_LENGTH; i++) begin
                if (6'(i) + 6'd1 == len_q) buf_d[8*i +: 8] = 8'h00;
              end
              len_d = len_q - 6'd1;
            end
          end
        end
        ST_ESCAPE: begin
          if (is_colour_digit(data_received)) begin
            colour_d = COLOUR_WIDTH'(data_received - BYTE_DIGIT_0);
          end else begin
            drop_d = 1'b1;
          end
        end
        ST_UPDATE: begin
          if (cls.clear) begin
            buf_d    = '0;
            len_d    = '0;
            font_d   = FONT_MIN;
            colour_d = '0;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: drop_d = 1'b0;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    update_valid = (state_q == ST_UPDATE);
    byte_dropped = drop_q;
    text_buffer  = buf_q;
    text_length  = len_q;
    font_size    = font_q;
    text_colour  = colour_q;
  end

endmodule

// File: tb/tb_text_command_parser.sv
// Directed bench for text_command_parser at default parameters: a vector table of
// per-cycle stimulus and expected outputs, then hand sequences for buffer fill,
// clear during handshake, async reset and 0x08 handling (TEXT_BACKSPACE_EN aware).
module tb_text_command_parser;

  logic         system_clock = 1'b0;
  logic         system_reset = 1'b1;
  logic [7:0]   data_received = 8'h00;
  logic         received_flag = 1'b0;
  logic         update_ready = 1'b0;
  logic [127:0] text_buffer;
  logic [5:0]   text_length;
  logic [1:0]   font_size;
  logic [2:0]   text_colour;
  logic         update_valid;
  logic         byte_dropped;

  int errors = 0;
  int checks = 0;

  text_command_parser dut (
    .system_clock  (system_clock),
    .system_reset  (system_reset),
    .data_received (data_received),
    .received_flag (received_flag),
    .text_buffer   (text_buffer),
    .text_length   (text_length),
    .font_size     (font_size),
    .text_colour   (text_colour),
    .update_valid  (update_valid),
    .update_ready  (update_ready),
    .byte_dropped  (byte_dropped)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    logic       rst;
    logic       flg;
    logic [7:0] dat;
    logic       rdy;
    logic [5:0] len;
    logic [1:0] font;
    logic [2:0] col;
    logic       vld;
    logic       drop;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic flg, input logic [7:0] dat,
                              input logic rdy, input logic [5:0] len, input logic [1:0] font,
                              input logic [2:0] col, input logic vld, input logic drop);
    vec_t v;
    v.rst = rst; v.flg = flg; v.dat = dat; v.rdy = rdy;
    v.len = len; v.font = font; v.col = col; v.vld = vld; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] len, input logic [1:0] font,
                          input logic [2:0] col, input logic vld, input logic drop);
    chk({tag, ".len"},  64'(text_length),  64'(len));
    chk({tag, ".font"}, 64'(font_size),    64'(font));
    chk({tag, ".col"},  64'(text_colour),  64'(col));
    chk({tag, ".vld"},  64'(update_valid), 64'(vld));
    chk({tag, ".drop"}, 64'(byte_dropped), 64'(drop));
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return text_buffer[8*i +: 8];
  endfunction

  // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic flg, input logic [7:0] d, input logic rdy);
    @(negedge system_clock);
    system_reset  = rst;
    received_flag = flg;
    data_received = d;
    update_ready  = rdy;
    @(posedge system_clock);
    #1;
  endtask

  initial begin
    //              rst flg dat    rdy  len font col vld drop
    vecs[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);  // reset
    vecs[1]  = mk(0, 1, 8'h41, 1, 1, 0, 0, 0, 0);  // 'A'
    vecs[2]  = mk(0, 1, 8'h42, 1, 2, 0, 0, 0, 0);  // 'B'
    vecs[3]  = mk(0, 1, 8'h0D, 1, 2, 0, 0, 1, 0);  // commit
    vecs[4]  = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 0);  // accepted: one-cycle valid
    vecs[5]  = mk(0, 1, 8'h2B, 0, 2, 1, 0, 1, 0);  // '+' -> 1
    vecs[6]  = mk(0, 0, 8'h00, 0, 2, 1, 0, 1, 0);  // held without ready
    vecs[7]  = mk(0, 1, 8'h56, 0, 2, 1, 0, 1, 1);  // 'V' in UPDATE dropped
    vecs[8]  = mk(0, 0, 8'h00, 1, 2, 1, 0, 0, 0);  // accepted
    vecs[9]  = mk(0, 1, 8'h2B, 1, 2, 2, 0, 1, 0);  // '+' -> 2
    vecs[10] = mk(0, 0, 8'h00, 1, 2, 2, 0, 0, 0);
    vecs[11] = mk(0, 1, 8'h2B, 1, 2, 3, 0, 1, 0);  // '+' -> 3
    vecs[12] = mk(0, 0, 8'h00, 1, 2, 3, 0, 0, 0);
    vecs[13] = mk(0, 1, 8'h2B, 1, 2, 3, 0, 1, 0);  // '+' at max holds 3
    vecs[14] = mk(0, 0, 8'h00, 1, 2, 3, 0, 0, 0);
    vecs[15] = mk(0, 1, 8'h2D, 1, 2, 2, 0, 1, 0);  // '-' -> 2
    vecs[16] = mk(0, 0, 8'h00, 1, 2, 2, 0, 0, 0);
    vecs[17] = mk(0, 1, 8'h7E, 1, 2, 2, 0, 0, 0);  // '~'
    vecs[18] = mk(0, 1, 8'h35, 1, 2, 2, 5, 1, 0);  // '5' -> colour 5
    vecs[19] = mk(0, 0, 8'h00, 1, 2, 2, 5, 0, 0);
    vecs[20] = mk(0, 1, 8'h7E, 1, 2, 2, 5, 0, 0);  // '~'
    vecs[21] = mk(0, 1, 8'h5A, 1, 2, 2, 5, 0, 1);  // 'Z' not a digit: dropped
    vecs[22] = mk(0, 1, 8'h43, 1, 3, 2, 5, 0, 0);  // 'C' appended: back in IDLE
    vecs[23] = mk(0, 1, 8'h23, 1, 0, 0, 0, 1, 0);  // '#' clears
    vecs[24] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 1, 8'h2D, 1, 0, 0, 0, 1, 0);  // '-' at min holds 0
    vecs[26] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].flg, vecs[i].dat, vecs[i].rdy);
      chk_outs($sformatf("vec%0d", i), vecs[i].len, vecs[i].font, vecs[i].col,
               vecs[i].vld, vecs[i].drop);
      if (i == 3) begin
        chk("ab.byte0", 64'(byte_at(0)), 64'h41);
        chk("ab.byte1", 64'(byte_at(1)), 64'h42);
        chk("ab.byte2", 64'(byte_at(2)), 64'h00);
      end
    end

    // Fill 16 characters: the 16th publishes, a 17th in IDLE is dropped.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h61 + 8'(i), 0);
      chk($sformatf("fill%0d.len", i), 64'(text_length), 64'(i + 1));
      chk($sformatf("fill%0d.vld", i), 64'(update_valid), (i == 15) ? 64'd1 : 64'd0);
    end
    chk("fill.byte0",  64'(byte_at(0)),  64'h61);
    chk("fill.byte15", 64'(byte_at(15)), 64'h70);
    drive(0, 0, 8'h00, 1);
    chk("fill.ack.vld", 64'(update_valid), 64'd0);
    drive(0, 1, 8'h71, 1);
    chk_outs("fill17", 16, 0, 0, 0, 1);
    chk("fill17.byte15", 64'(byte_at(15)), 64'h70);

    // Clear during an unacknowledged update.
    drive(0, 1, 8'h7E, 1);
    drive(0, 1, 8'h36, 1);
    chk_outs("col6", 16, 0, 6, 1, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h2B, 0);
    chk_outs("pre_clr", 16, 1, 6, 1, 0);
    drive(0, 1, 8'h23, 0);
    chk_outs("clr_upd", 0, 0, 0, 1, 0);
    chk("clr_upd.buf_zero", 64'(text_buffer == 128'd0), 64'd1);
    drive(0, 0, 8'h00, 0);
    chk("clr_upd.vld_held", 64'(update_valid), 64'd1);

    // Build non-reset contents, then reset asynchronously mid-handshake.
    drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h4D, 0);
    drive(0, 1, 8'h7E, 0);
    drive(0, 1, 8'h33, 0);
    chk_outs("pre_rst", 1, 0, 3, 1, 0);
    @(negedge system_clock);
    received_flag = 1'b0;
    system_reset  = 1'b1;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.buf_zero", 64'(text_buffer == 128'd0), 64'd1);
    drive(0, 0, 8'h00, 0);
    chk_outs("post_rst", 0, 0, 0, 0, 0);

`ifdef TEXT_BACKSPACE_EN
    drive(0, 1, 8'h58, 0);
    drive(0, 1, 8'h59, 0);
    drive(0, 1, 8'h08, 0);
    chk_outs("bksp", 1, 0, 0, 0, 0);
    chk("bksp.byte0", 64'(byte_at(0)), 64'h58);
    chk("bksp.byte1", 64'(byte_at(1)), 64'h00);
    drive(0, 1, 8'h08, 0);
    chk_outs("bksp_to0", 0, 0, 0, 0, 0);
    drive(0, 1, 8'h08, 0);
    chk_outs("bksp_empty", 0, 0, 0, 0, 0);
`else
    drive(0, 1, 8'h08, 0);
    chk_outs("bs_char", 1, 0, 0, 0, 0);
    chk("bs_char.byte0", 64'(byte_at(0)), 64'h08);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
